// File: rtl/mux4_rr_select.sv
// Round-robin select generator for a 4:1 mux: registered select, one-hot grant and valid,
// with a hold limit that force-rotates long grants and flags the rotation on TOUT.
module mux4_rr_select #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       CK,
    input  logic       RN,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [1:0] S,
    output logic [3:0] GNT,
    output logic       VLD,
    output logic       TOUT
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      s_q, s_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            tout_q, tout_d;

    logic            at_limit;
    logic            rel;
    logic [1:0]      arb_ptr;
    logic            win;
    logic [1:0]      win_idx;

    // Returns {found, index} of the first requester at or after ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        gnt_d    = gnt_q;
        tout_d   = 1'b0;
        at_limit = (cnt_q == CntW'(MAX_HOLD));
        rel      = DONE || !REQ[s_q] || at_limit;
        // On release the pointer moves past the grantee first, so it is searched last.
        arb_ptr  = (state_q == StBusy) ? s_q + 2'd1 : ptr_q;
        {win, win_idx} = rr_pick(REQ, arb_ptr);

        unique case (state_q)
            StIdle: begin
                if (win) begin
                    state_d = StBusy;
                    s_d     = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    cnt_d   = CntW'(1);
                end
            end
            StBusy: begin
                if (rel) begin
                    ptr_d  = s_q + 2'd1;
                    tout_d = at_limit && !DONE && REQ[s_q];
                    if (win) begin
                        s_d   = win_idx;
                        gnt_d = 4'b0001 << win_idx;
                        cnt_d = CntW'(1);
                    end else begin
                        // S keeps its value so the mux does not switch spuriously.
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StIdle;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
            s_q     <= 2'b00;
            gnt_q   <= 4'b0000;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            tout_q  <= tout_d;
        end
    end

    assign S    = s_q;
    assign GNT  = gnt_q;
    assign VLD  = (state_q == StBusy);
    assign TOUT = tout_q;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Bench for mux4_rr_select: two instances (hold limits 4 and 1) driven by the same directed
// and random stimulus, checked every cycle against a round-robin model.
module tb_mux4_rr_select;

    localparam int HoldA = 4;
    localparam int HoldB = 1;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic [3:0] REQ = 4'b0000;
    logic       DONE = 1'b0;

    logic [1:0] s_a, s_b;
    logic [3:0] gnt_a, gnt_b;
    logic       vld_a, vld_b, tout_a, tout_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 -> HoldA, 1 -> HoldB.
    int m_busy[2];
    int m_s[2];
    int m_cnt[2];
    int m_ptr[2];
    int m_tout[2];

    mux4_rr_select #(.MAX_HOLD(HoldA)) dut_a (
        .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
        .S(s_a), .GNT(gnt_a), .VLD(vld_a), .TOUT(tout_a)
    );

    mux4_rr_select #(.MAX_HOLD(HoldB)) dut_b (
        .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
        .S(s_b), .GNT(gnt_b), .VLD(vld_b), .TOUT(tout_b)
    );

    always #5 CK = ~CK;

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            m_busy[h] = 0; m_s[h] = 0; m_cnt[h] = 0; m_ptr[h] = 0; m_tout[h] = 0;
        end
    endtask

    task automatic model_step(input int h, input logic [3:0] req, input logic done);
        int lim;
        int start;
        int w;
        lim = (h == 0) ? HoldA : HoldB;
        m_tout[h] = 0;
        if (m_busy[h] != 0) begin
            if (done || !req[m_s[h]] || m_cnt[h] == lim) begin
                m_tout[h] = (!done && req[m_s[h]] && m_cnt[h] == lim) ? 1 : 0;
                m_ptr[h] = (m_s[h] + 1) % 4;
            end else begin
                m_cnt[h]++;
                return;
            end
        end
        start = m_ptr[h];
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && req[(start + k) % 4]) w = (start + k) % 4;
        end
        if (w >= 0) begin
            m_busy[h] = 1; m_s[h] = w; m_cnt[h] = 1;
        end else begin
            m_busy[h] = 0; m_cnt[h] = 0;
        end
    endtask

    task automatic check_one(input string tag, input int h, input logic [1:0] s,
                             input logic [3:0] gnt, input logic vld, input logic tout);
        logic [1:0] e_s;
        logic [3:0] e_gnt;
        logic       e_vld;
        logic       e_tout;
        e_s    = 2'(m_s[h]);
        e_gnt  = (m_busy[h] != 0) ? (4'b0001 << m_s[h]) : 4'b0000;
        e_vld  = (m_busy[h] != 0);
        e_tout = (m_tout[h] != 0);
        checks += 4;
        assert (s === e_s) else begin
            errors++;
            $error("FAIL %s S[%0d]: got %0d expected %0d", tag, h, s, e_s);
        end
        assert (gnt === e_gnt) else begin
            errors++;
            $error("FAIL %s GNT[%0d]: got %b expected %b", tag, h, gnt, e_gnt);
        end
        assert (vld === e_vld) else begin
            errors++;
            $error("FAIL %s VLD[%0d]: got %b expected %b", tag, h, vld, e_vld);
        end
        assert (tout === e_tout) else begin
            errors++;
            $error("FAIL %s TOUT[%0d]: got %b expected %b", tag, h, tout, e_tout);
        end
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 0, s_a, gnt_a, vld_a, tout_a);
        check_one(tag, 1, s_b, gnt_b, vld_b, tout_b);
    endtask

    task automatic step(input string tag, input logic [3:0] req, input logic done);
        REQ  = req;
        DONE = done;
        @(posedge CK);
        model_step(0, req, done);
        model_step(1, req, done);
        #1 check_all(tag);
    endtask

    initial begin
        model_reset();
        #2 check_all("reset");
        @(negedge CK);
        RN = 1'b1;

        step("idle", 4'b0000, 1'b0);
        step("idle", 4'b0000, 1'b0);

        // Single requester, then release with DONE and request drop.
        step("single", 4'b0100, 1'b0);
        step("single", 4'b0100, 1'b0);
        step("single", 4'b0100, 1'b0);
        step("single_done", 4'b0000, 1'b1);
        step("single_idle", 4'b0000, 1'b0);

        // Round robin with DONE every cycle.
        for (int i = 0; i < 6; i++) step("rr", 4'b1111, 1'b1);

        // Hold limit rotation between two requesters.
        for (int i = 0; i < 14; i++) step("hold", 4'b0011, 1'b0);

        // Grantee drops, another input requests.
        step("drop_pre", 4'b0000, 1'b1);
        step("drop_pre", 4'b0000, 1'b0);
        step("drop_g1", 4'b0010, 1'b0);
        step("drop_sw", 4'b1000, 1'b0);
        step("drop_hold", 4'b1000, 1'b0);

        // Sole requester re-granted when DONE and limit coincide.
        for (int i = 0; i < 6; i++) step("regrant", 4'b0001, (i % 4) == 3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

        // Asynchronous reset while busy on index 3.
        step("pre_rst", 4'b1000, 1'b1);
        step("pre_rst", 4'b1000, 1'b0);
        #2 RN = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(posedge CK);
        #1 check_all("rst_held");
        @(negedge CK);
        RN = 1'b1;
        step("post_rst", 4'b1111, 1'b0);
        step("post_rst", 4'b1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
